// File: rtl/limn2600_timer_pkg.sv
// Shared constants for the limn2600 interval timer: register byte offsets,
// CTRL/STATUS bit positions, bus FSM states and the prescale width.
package limn2600_timer_pkg;

  // Register byte offsets (only bits [4:2] are decoded)
  localparam logic [4:0] OFF_CTRL     = 5'h00;
  localparam logic [4:0] OFF_COUNT    = 5'h04;
  localparam logic [4:0] OFF_RELOAD   = 5'h08;
  localparam logic [4:0] OFF_STATUS   = 5'h0C;
  localparam logic [4:0] OFF_PRESCALE = 5'h10;

  // CTRL bit positions
  localparam int CTRL_EN   = 0;
  localparam int CTRL_IE   = 1;
  localparam int CTRL_AUTO = 2;

  // STATUS bit positions
  localparam int STATUS_EXP = 0;

  // Width of the PRESCALE register and prescale counter
  localparam int PRESCALE_W = 16;

  // Bus handshake states
  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } bus_state_e;

endpackage

// File: rtl/limn2600_timer_prescaler.sv
// Tick generator: emits one tick every PRESCALE+1 cycles while enabled.
// Used only when LIMN2600_TIMER_PRESCALER_EN is defined.
module limn2600_timer_prescaler
  import limn2600_timer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  // Tick on match; counter restarts on match and is held at 0 while disabled
  always_comb begin
    tick  = en && (cnt_q == prescale);
    cnt_d = cnt_q + 1'b1;
    if (!en || tick) begin
      cnt_d = '0;
    end
  end

  // Prescale counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/limn2600_timer.sv
// limn2600 interval timer with a two-cycle CS/RDY register interface.
// Optional prescaler enabled by defining LIMN2600_TIMER_PRESCALER_EN.
module limn2600_timer
  import limn2600_timer_pkg::*;
#(
  parameter logic [31:0] RESET_RELOAD = 32'h0000_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        rdy,
  output logic        irq
);

  localparam logic [2:0] IDX_CTRL     = OFF_CTRL[4:2];
  localparam logic [2:0] IDX_COUNT    = OFF_COUNT[4:2];
  localparam logic [2:0] IDX_RELOAD   = OFF_RELOAD[4:2];
  localparam logic [2:0] IDX_STATUS   = OFF_STATUS[4:2];
  localparam logic [2:0] IDX_PRESCALE = OFF_PRESCALE[4:2];

  bus_state_e  state_q, state_d;
  logic        en_q, en_d, ie_q, ie_d, auto_q, auto_d;
  logic        exp_q, exp_d, irq_q, irq_d;
  logic [31:0] count_q, count_d, reload_q, reload_d;
  logic [31:0] rdata_q, read_val;
  logic        accept, wr, tick, expire;
  logic [2:0]  idx;
  logic        unused_addr;

  assign idx         = addr[4:2];
  assign accept      = (state_q == IDLE) && cs;
  assign wr          = accept && we;
  assign irq         = irq_q;
  assign unused_addr = ^{addr[31:5], addr[1:0]};

`ifdef LIMN2600_TIMER_PRESCALER_EN
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;

  limn2600_timer_prescaler u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (en_q),
    .prescale (prescale_q),
    .tick     (tick)
  );

  // PRESCALE register write
  always_comb begin
    prescale_d = prescale_q;
    if (wr && idx == IDX_PRESCALE) begin
      prescale_d = data_in[PRESCALE_W-1:0];
    end
  end

  // PRESCALE register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale_q <= '0;
    end else begin
      prescale_q <= prescale_d;
    end
  end
`else
  assign tick = en_q;
`endif

  // Bus FSM next state and handshake outputs; read data is only exposed during ACK
  always_comb begin
    state_d  = state_q;
    rdy      = 1'b0;
    data_out = '0;
    case (state_q)
      IDLE: if (cs) state_d = ACK;
      ACK: begin
        state_d  = IDLE;
        rdy      = 1'b1;
        data_out = rdata_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Register read mux, sampled on the accepting edge
  always_comb begin
    read_val = '0;
    case (idx)
      IDX_CTRL: begin
        read_val[CTRL_EN]   = en_q;
        read_val[CTRL_IE]   = ie_q;
        read_val[CTRL_AUTO] = auto_q;
      end
      IDX_COUNT:  read_val = count_q;
      IDX_RELOAD: read_val = reload_q;
      IDX_STATUS: read_val[STATUS_EXP] = exp_q;
`ifdef LIMN2600_TIMER_PRESCALER_EN
      IDX_PRESCALE: read_val[PRESCALE_W-1:0] = prescale_q;
`endif
      default: read_val = '0;
    endcase
  end

  // Countdown, expiry and CPU writes; CPU writes override the timer update
  always_comb begin
    en_d     = en_q;
    ie_d     = ie_q;
    auto_d   = auto_q;
    count_d  = count_q;
    reload_d = reload_q;
    exp_d    = exp_q;
    expire   = 1'b0;

    // COUNT of 0 expires like COUNT of 1 instead of wrapping
    if (en_q && tick) begin
      if (count_q <= 32'd1) begin
        expire = 1'b1;
        if (auto_q) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          en_d    = 1'b0;
        end
      end else begin
        count_d = count_q - 32'd1;
      end
    end

    if (wr && idx == IDX_CTRL) begin
      en_d   = data_in[CTRL_EN];
      ie_d   = data_in[CTRL_IE];
      auto_d = data_in[CTRL_AUTO];
    end
    if (wr && idx == IDX_COUNT) begin
      count_d = data_in;
    end
    if (wr && idx == IDX_RELOAD) begin
      reload_d = data_in;
    end
    if (wr && idx == IDX_STATUS && data_in[STATUS_EXP]) begin
      exp_d = 1'b0;
    end
    // A simultaneous expiry beats the write-1-to-clear
    if (expire) begin
      exp_d = 1'b1;
    end

    irq_d = exp_q && ie_q;
  end

  // State and register update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rdata_q  <= '0;
      en_q     <= 1'b0;
      ie_q     <= 1'b0;
      auto_q   <= 1'b0;
      count_q  <= '0;
      reload_q <= RESET_RELOAD;
      exp_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      if (accept) begin
        rdata_q <= read_val;
      end
      en_q     <= en_d;
      ie_q     <= ie_d;
      auto_q   <= auto_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      exp_q    <= exp_d;
      irq_q    <= irq_d;
    end
  end

endmodule

// File: tb/tb_limn2600_timer.sv
// Self-checking bench for limn2600_timer: directed scenarios plus randomized
// countdown runs checked against an arithmetic model of the timer.
module tb_limn2600_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        rdy;
  logic        irq;

  int          passed = 0;
  int          total = 0;
  int unsigned edge_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  limn2600_timer dut (
    .clk      (clk),
    .rst      (rst),
    .cs       (cs),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .rdy      (rdy),
    .irq      (irq)
  );

  // Model: COUNT after n ticks from a start value c (0 behaves as 1)
  function automatic logic [31:0] m_count(int c, int r, bit au, int n);
    int ce;
    ce = (c == 0) ? 1 : c;
    if (n < ce) return 32'(c - n);
    if (!au) return 32'd0;
    return 32'(r - ((n - ce) % r));
  endfunction

  // Model: EXP after n ticks from start value c
  function automatic logic m_exp(int c, int n);
    return n >= ((c == 0) ? 1 : c);
  endfunction

  // One bus access; must be called just after a clock edge
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output int unsigned ta, output logic irq_ack);
    cs = 1'b1; we = w; addr = a; data_in = wd;
    @(posedge clk); #1;
    ta = edge_cnt;
    cs = 1'b0; we = 1'b0;
    rd = data_out;
    irq_ack = irq;
    total++;
    if (rdy !== 1'b1) $display("FAIL bus_rdy addr=%h got=%b want=1", a, rdy);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (rdy !== 1'b0 || data_out !== 32'd0)
      $display("FAIL bus_idle addr=%h rdy=%b data_out=%h want rdy=0 data_out=0", a, rdy, data_out);
    else passed++;
    $display("bus %s addr=%h wdata=%h rdata=%h edge=%0d", w ? "WR" : "RD", a, wd, rd, ta);
  endtask

  task automatic wait_to(input int unsigned e);
    while (edge_cnt < e) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; cs = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; int unsigned ta; logic ia;
    #2;
    total++;
    if (rdy !== 1'b0 || data_out !== 32'd0 || irq !== 1'b0)
      $display("FAIL reset_outputs rdy=%b data_out=%h irq=%b want 0/0/0", rdy, data_out, irq);
    else passed++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus(1'b0, 32'h00, 0, rd, ta, ia);
    total++; if (rd !== 32'd0) $display("FAIL reset_ctrl got=%h want=0", rd); else passed++;
    bus(1'b0, 32'h04, 0, rd, ta, ia);
    total++; if (rd !== 32'd0) $display("FAIL reset_count got=%h want=0", rd); else passed++;
    bus(1'b0, 32'h08, 0, rd, ta, ia);
    total++; if (rd !== 32'h0000_FFFF) $display("FAIL reset_reload got=%h want=0000ffff", rd); else passed++;
    bus(1'b0, 32'h0C, 0, rd, ta, ia);
    total++; if (rd !== 32'd0) $display("FAIL reset_status got=%h want=0", rd); else passed++;
    bus(1'b0, 32'h10, 0, rd, ta, ia);
    total++; if (rd !== 32'd0) $display("FAIL reset_prescale got=%h want=0", rd); else passed++;
  endtask

  task automatic test_oneshot();
    logic [31:0] rd; int unsigned ta, t0; logic ia;
    do_reset();
    bus(1'b1, 32'h08, 32'd5, rd, ta, ia);
    bus(1'b1, 32'h04, 32'd3, rd, ta, ia);
    bus(1'b1, 32'h00, 32'h3, rd, t0, ia);
    wait_to(t0 + 3);
    total++; if (irq !== 1'b0) $display("FAIL oneshot_irq_lag got=%b want=0", irq); else passed++;
    @(posedge clk); #1;
    total++; if (irq !== 1'b1) $display("FAIL oneshot_irq got=%b want=1", irq); else passed++;
    bus(1'b0, 32'h00, 0, rd, ta, ia);
    total++; if (rd !== 32'h2) $display("FAIL oneshot_ctrl got=%h want=2", rd); else passed++;
    bus(1'b0, 32'h04, 0, rd, ta, ia);
    total++; if (rd !== 32'd0) $display("FAIL oneshot_count got=%h want=0", rd); else passed++;
    bus(1'b0, 32'h0C, 0, rd, ta, ia);
    total++; if (rd !== 32'd1) $display("FAIL oneshot_status got=%h want=1", rd); else passed++;
  endtask

  task automatic test_autoreload();
    logic [31:0] rd, exp_v; int unsigned ta, t0; logic ia;
    do_reset();
    bus(1'b1, 32'h08, 32'd2, rd, ta, ia);
    bus(1'b1, 32'h04, 32'd2, rd, ta, ia);
    bus(1'b1, 32'h00, 32'h7, rd, t0, ia);
    for (int i = 0; i < 4; i++) begin
      bus(1'b0, 32'h04, 0, rd, ta, ia);
      exp_v = m_count(2, 2, 1'b1, int'(ta - 1 - t0));
      total++;
      if (rd !== exp_v) $display("FAIL auto_count[%0d] got=%h want=%h", i, rd, exp_v); else passed++;
      @(posedge clk); #1;
    end
    bus(1'b1, 32'h00, 32'h2, rd, ta, ia);
    total++; if (irq !== 1'b1) $display("FAIL auto_irq_set got=%b want=1", irq); else passed++;
    bus(1'b1, 32'h0C, 32'h1, rd, ta, ia);
    total++; if (ia !== 1'b1) $display("FAIL auto_irq_lag got=%b want=1", ia); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL auto_irq_clear got=%b want=0", irq); else passed++;
    bus(1'b0, 32'h0C, 0, rd, ta, ia);
    total++; if (rd !== 32'd0) $display("FAIL auto_status_clear got=%h want=0", rd); else passed++;
  endtask

  task automatic test_rw();
    logic [31:0] rd, v; int unsigned ta; logic ia;
    do_reset();
    bus(1'b1, 32'h08, 32'hDEAD_BEEF, rd, ta, ia);
    bus(1'b0, 32'h08, 0, rd, ta, ia);
    total++; if (rd !== 32'hDEAD_BEEF) $display("FAIL rw_deadbeef got=%h want=deadbeef", rd); else passed++;
    for (int i = 0; i < 3; i++) begin
      v = $urandom;
      bus(1'b1, 32'h08 | 32'(i) << 5, v, rd, ta, ia);
      bus(1'b0, 32'h08, 0, rd, ta, ia);
      total++; if (rd !== v) $display("FAIL rw_reload[%0d] got=%h want=%h", i, rd, v); else passed++;
      v = $urandom & 32'hFFFF_FFFE;
      bus(1'b1, 32'h00, v, rd, ta, ia);
      bus(1'b0, 32'h00, 0, rd, ta, ia);
      total++; if (rd !== (v & 32'h6)) $display("FAIL rw_ctrl[%0d] got=%h want=%h", i, rd, v & 32'h6); else passed++;
      v = $urandom;
      bus(1'b1, 32'h14 + 32'(4 * i), v, rd, ta, ia);
      bus(1'b0, 32'h14 + 32'(4 * i), 0, rd, ta, ia);
      total++; if (rd !== 32'd0) $display("FAIL rw_unmapped[%0d] got=%h want=0", i, rd); else passed++;
      bus(1'b1, 32'h0C, $urandom, rd, ta, ia);
      bus(1'b0, 32'h0C, 0, rd, ta, ia);
      total++; if (rd !== 32'd0) $display("FAIL rw_status[%0d] got=%h want=0", i, rd); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, v; int unsigned ta; logic ia;
    do_reset();
    v = $urandom;
    bus(1'b1, 32'h08, v, rd, ta, ia);
    cs = 1'b1; we = 1'b0; addr = 32'h08;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 3) cs = 1'b0;
      total++;
      if (rdy !== (i % 2 == 0) || data_out !== ((i % 2 == 0) ? v : 32'd0))
        $display("FAIL b2b[%0d] rdy=%b data_out=%h want rdy=%0d data_out=%h", i, rdy, data_out,
                 (i % 2 == 0), (i % 2 == 0) ? v : 32'd0);
      else passed++;
    end
    cs = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_w1c_race();
    logic [31:0] rd, exp_v; int unsigned ta, t0, t1; logic ia;
    do_reset();
    bus(1'b1, 32'h04, 32'd2, rd, ta, ia);
    bus(1'b1, 32'h00, 32'h3, rd, t0, ia);
    bus(1'b1, 32'h0C, 32'h1, rd, ta, ia);
    bus(1'b0, 32'h0C, 0, rd, ta, ia);
    total++; if (rd !== 32'd1) $display("FAIL w1c_race_exp got=%h want=1", rd); else passed++;
    do_reset();
    bus(1'b1, 32'h04, 32'd100, rd, ta, ia);
    bus(1'b1, 32'h00, 32'h1, rd, t0, ia);
    bus(1'b1, 32'h04, 32'd50, rd, t1, ia);
    bus(1'b0, 32'h04, 0, rd, ta, ia);
    exp_v = 32'd50 - (ta - 1 - t1);
    total++; if (rd !== exp_v) $display("FAIL count_write_prio got=%h want=%h", rd, exp_v); else passed++;
    do_reset();
    bus(1'b1, 32'h04, 32'd2, rd, ta, ia);
    bus(1'b1, 32'h00, 32'h1, rd, t0, ia);
    bus(1'b1, 32'h00, 32'h5, rd, ta, ia);
    bus(1'b0, 32'h00, 0, rd, ta, ia);
    total++; if (rd !== 32'h5) $display("FAIL ctrl_write_prio got=%h want=5", rd); else passed++;
  endtask

  task automatic test_reset_in_ack();
    logic [31:0] rd; int unsigned ta; logic ia;
    do_reset();
    bus(1'b1, 32'h04, 32'd1000, rd, ta, ia);
    bus(1'b1, 32'h00, 32'h1, rd, ta, ia);
    cs = 1'b1; we = 1'b0; addr = 32'h08;
    @(posedge clk); #1;
    cs = 1'b0;
    total++; if (rdy !== 1'b1) $display("FAIL rst_ack_pre rdy=%b want=1", rdy); else passed++;
    #1 rst = 1'b1;
    #1;
    total++;
    if (rdy !== 1'b0 || data_out !== 32'd0 || irq !== 1'b0)
      $display("FAIL rst_ack_now rdy=%b data_out=%h irq=%b want 0/0/0", rdy, data_out, irq);
    else passed++;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    total++; if (rdy !== 1'b0) $display("FAIL rst_ack_norepl rdy=%b want=0", rdy); else passed++;
    bus(1'b0, 32'h00, 0, rd, ta, ia);
    total++; if (rd !== 32'd0) $display("FAIL rst_ack_ctrl got=%h want=0", rd); else passed++;
    bus(1'b0, 32'h04, 0, rd, ta, ia);
    total++; if (rd !== 32'd0) $display("FAIL rst_ack_count got=%h want=0", rd); else passed++;
    bus(1'b0, 32'h08, 0, rd, ta, ia);
    total++; if (rd !== 32'h0000_FFFF) $display("FAIL rst_ack_reload got=%h want=0000ffff", rd); else passed++;
  endtask

  task automatic test_prescale();
    logic [31:0] rd, v; int unsigned ta, t0; logic ia;
    do_reset();
`ifdef LIMN2600_TIMER_PRESCALER_EN
    bus(1'b1, 32'h10, 32'hABCD_0003, rd, ta, ia);
    bus(1'b0, 32'h10, 0, rd, ta, ia);
    total++; if (rd !== 32'h3) $display("FAIL prescale_rw got=%h want=3", rd); else passed++;
    bus(1'b1, 32'h04, 32'd2, rd, ta, ia);
    bus(1'b1, 32'h00, 32'h3, rd, t0, ia);
    wait_to(t0 + 8);
    total++; if (irq !== 1'b0) $display("FAIL prescale_early irq=%b want=0", irq); else passed++;
    @(posedge clk); #1;
    total++; if (irq !== 1'b1) $display("FAIL prescale_expire irq=%b want=1", irq); else passed++;
`else
    v = $urandom;
    bus(1'b1, 32'h10, v, rd, ta, ia);
    bus(1'b0, 32'h10, 0, rd, ta, ia);
    total++; if (rd !== 32'd0) $display("FAIL prescale_absent got=%h want=0", rd); else passed++;
    bus(1'b1, 32'h04, 32'd2, rd, ta, ia);
    bus(1'b1, 32'h00, 32'h3, rd, t0, ia);
    wait_to(t0 + 2);
    total++; if (irq !== 1'b0) $display("FAIL noprescale_early irq=%b want=0", irq); else passed++;
    @(posedge clk); #1;
    total++; if (irq !== 1'b1) $display("FAIL noprescale_expire irq=%b want=1", irq); else passed++;
`endif
  endtask

  task automatic test_random();
    logic [31:0] rd, exp_v; int unsigned ta, t0; logic ia;
    int c, r, n; bit au;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      c  = int'($urandom_range(0, 12));
      r  = int'($urandom_range(1, 6));
      au = 1'($urandom_range(0, 1));
      bus(1'b1, 32'h08, 32'(r), rd, ta, ia);
      bus(1'b1, 32'h04, 32'(c), rd, ta, ia);
      bus(1'b1, 32'h00, {29'd0, au, 2'b11}, rd, t0, ia);
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          @(posedge clk); #1;
        end
        bus(1'b0, (k % 2 == 0) ? 32'h04 : 32'h0C, 0, rd, ta, ia);
        n = int'(ta - 1 - t0);
        exp_v = (k % 2 == 0) ? m_count(c, r, au, n) : {31'd0, m_exp(c, n)};
        total++;
        if (rd !== exp_v)
          $display("FAIL rand[%0d.%0d] c=%0d r=%0d auto=%0d n=%0d got=%h want=%h", it, k, c, r, au, n, rd, exp_v);
        else passed++;
        n = int'(ta - t0);
        total++;
        if (irq !== m_exp(c, n))
          $display("FAIL rand_irq[%0d.%0d] n=%0d got=%b want=%b", it, k, n, irq, m_exp(c, n));
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_rw();
    test_back_to_back();
    test_w1c_race();
    test_reset_in_ack();
    test_prescale();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/limn2600_timer.md
LIMN2600_TIMER -- requirements
Module: limn2600_timer

Interface
REQ-001 SHALL have parameter RESET_RELOAD, default 32'h0000_FFFF, the reset value of RELOAD.
REQ-002 SHALL have ports: clk, input, 1, system clock, all state on rising edge.
REQ-003 SHALL have ports: rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports: cs, input, 1, chip select from the system decoder; access request.
REQ-005 SHALL have ports: we, input, 1, write when 1, read when 0; qualified by cs.
REQ-006 SHALL have ports: addr, input, 32, byte address; only addr[4:2] decoded.
REQ-007 SHALL have ports: data_in, input, 32, write data from the CPU.
REQ-008 SHALL have ports: data_out, output, 32, read data, valid only while rdy=1, else 0.
REQ-009 SHALL have ports: rdy, output, 1, one-cycle access-complete strobe.
REQ-010 SHALL have ports: irq, output, 1, level interrupt request to the CPU.

Function
REQ-011 SHALL run a two-state bus FSM: IDLE -> ACK when cs=1 in IDLE; ACK -> IDLE unconditionally.
REQ-012 SHALL assert rdy exactly in ACK, one cycle after the accepting edge; cs is ignored in ACK, so back-to-back accesses complete every 2 cycles.
REQ-013 SHALL perform register writes and capture read data on the accepting edge (IDLE, cs=1).
REQ-014 SHALL map registers at offsets: 0x00 CTRL, 0x04 COUNT, 0x08 RELOAD, 0x0C STATUS, 0x10 PRESCALE.
REQ-015 CTRL SHALL hold bit0 EN, bit1 IE, bit2 AUTO; other bits read 0.
REQ-016 STATUS bit0 EXP SHALL be write-1-to-clear; other bits read 0 and ignore writes.
REQ-017 Unmapped offsets SHALL read 0, ignore writes, and still complete with rdy.
REQ-018 When EN=1 and a tick occurs, COUNT SHALL decrement by 1, modulo 2^32.
REQ-019 On a tick with COUNT=1, the block SHALL set EXP, then load RELOAD into COUNT if AUTO=1; otherwise it SHALL load 0 and clear EN.
REQ-020 With EN=1 and COUNT=0, a tick SHALL behave as COUNT=1 (expire), without wrapping to 32'hFFFF_FFFF.
REQ-021 A CPU write to COUNT or CTRL SHALL take priority over the decrement/reload in the same cycle.
REQ-022 An expiry in the same cycle as a W1C of EXP SHALL leave EXP=1 (set wins).
REQ-023 irq SHALL be driven from a register equal to EXP & IE, so it lags the EXP/IE change by one cycle.

Reset
REQ-024 Asserting rst SHALL immediately force: FSM=IDLE, rdy=0, data_out=0, irq=0, CTRL=0, COUNT=0, STATUS=0, RELOAD=RESET_RELOAD, PRESCALE=0, prescale counter=0.
REQ-025 Reset during ACK SHALL abort the access; no rdy is produced for it after reset release.

Configuration
REQ-026 With LIMN2600_TIMER_PRESCALER_EN defined:
- PRESCALE is a 16-bit RW register (bits[15:0]).
- A tick occurs when the prescale counter equals PRESCALE; the counter then returns to 0, otherwise it increments.
- The prescale counter clears when EN=0.
REQ-027 Without LIMN2600_TIMER_PRESCALER_EN:
- A tick occurs every cycle while EN=1.
- Offset 0x10 reads 0 and ignores writes.

Structure
REQ-028 Package limn2600_timer_pkg SHALL hold: register offset constants, CTRL/STATUS bit indices, the bus FSM state enum (IDLE, ACK), and the 16-bit prescale width constant.
REQ-029 Sub-module limn2600_timer_prescaler (tick generator) SHALL be instantiated only under LIMN2600_TIMER_PRESCALER_EN.

Verification
REQ-030 Write RELOAD=5, COUNT=3, CTRL=0x3 -> EXP=1 three ticks after EN sets; irq=1 one cycle later; EN clears; COUNT=0.
REQ-031 RELOAD=2, COUNT=2, CTRL=0x7 -> EXP sets every 2 ticks; COUNT follows 2,1,2,1; write STATUS=1 clears EXP and drops irq next cycle.
REQ-032 Read-after-write of offset 0x08 with 32'hDEAD_BEEF -> rdy pulses one cycle after each cs accept; read returns DEAD_BEEF; data_out=0 outside rdy.
REQ-033 W1C of STATUS on the exact expiry cycle -> EXP remains 1; COUNT write coincident with a tick -> written value is held.
REQ-034 Assert rst while in ACK with COUNT running -> rdy=0 at once; all registers at reset values; read of 0x08 returns 32'h0000_FFFF.
REQ-035 With the macro defined, PRESCALE=3 and COUNT=2 -> EXP sets after 8 cycles; without the macro, read of 0x10 returns 0.
